// File: rtl/slink_clk_seq_pkg.sv
// Shared types and helpers for the S-Link link clock sequencer.
// Optional feature macro used by the sequencer: SLINK_CLK_SEQ_LOCK_MONITOR_EN.
package slink_clk_seq_pkg;

  // Sequencer states; REF is the reset state (link on refclk, PLL off).
  typedef enum logic [2:0] {
    REF      = 3'd0,
    PLL_WAIT = 3'd1,
    SETTLE   = 3'd2,
    TO_PHY   = 3'd3,
    PHY      = 3'd4,
    TO_REF   = 3'd5
  } state_e;

  // Depth of the lock synchronizer in front of the FSM.
  localparam int SYNC_STAGES = 2;

  // Width of the shared phase counter: wide enough to hold the largest
  // of the three programmable phase lengths.
  function automatic int cnt_width(input int lock_timeout,
                                   input int settle_cycles,
                                   input int switch_cycles);
    int m;
    m = lock_timeout;
    if (settle_cycles > m) m = settle_cycles;
    if (switch_cycles > m) m = switch_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/slink_link_clk_seq_sync.sv
// Two-flop synchronizer cell for single-bit asynchronous level inputs.
module slink_link_clk_seq_sync
  import slink_clk_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the asynchronous input through the synchronizer chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  // Synchronizer flops, cleared by reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/slink_link_clk_seq.sv
// S-Link link clock sequencer: selects refclk or PHY clock for the link,
// sequencing PLL power-up, lock qualification and held-reset mux switches.
// Optional lock-loss monitor in PHY: SLINK_CLK_SEQ_LOCK_MONITOR_EN.
module slink_link_clk_seq
  import slink_clk_seq_pkg::*;
#(
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int SETTLE_CYCLES = 64,
  parameter int SWITCH_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic phy_clk_req,
  input  logic phy_pll_lock,
  input  logic err_clr,
  output logic phy_pll_en,
  output logic use_phy_clk,
  output logic link_hold,
  output logic busy,
  output logic on_phy_clk,
  output logic lock_timeout_err,
  output logic lock_lost_err
);

  localparam int CNT_W = cnt_width(LOCK_TIMEOUT, SETTLE_CYCLES, SWITCH_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SWITCH_LAST  = CNT_W'(SWITCH_CYCLES - 1);

  logic             lock_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phy_pll_en_q, phy_pll_en_d;
  logic             use_phy_clk_q, use_phy_clk_d;
  logic             link_hold_q, link_hold_d;
  logic             busy_q, busy_d;
  logic             on_phy_clk_q, on_phy_clk_d;
  logic             lock_timeout_err_q, lock_timeout_err_d;
  logic             timeout_set;
  logic             rearm_ok;
`ifdef SLINK_CLK_SEQ_LOCK_MONITOR_EN
  logic             lock_lost_err_q, lock_lost_err_d;
  logic             lost_set;
  logic             block_q, block_d;
`endif

  slink_link_clk_seq_sync u_lock_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (phy_pll_lock),
    .q     (lock_s)
  );

  // Next-state, shared counter, error flags and output decode of next state.
  // NOTE: every signal assigned below gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    timeout_set = 1'b0;
`ifdef SLINK_CLK_SEQ_LOCK_MONITOR_EN
    lost_set = 1'b0;
    // A lock-loss block lasts until software drops the request.
    block_d  = block_q & phy_clk_req;
    rearm_ok = !block_q;
`else
    rearm_ok = 1'b1;
`endif

    unique case (state_q)
      REF: begin
        cnt_d = '0;
        if (phy_clk_req && rearm_ok) state_d = PLL_WAIT;
      end
      PLL_WAIT: begin
        if (!phy_clk_req)              state_d = REF;
        else if (lock_s)               state_d = SETTLE;
        else if (cnt_q == TIMEOUT_LAST) begin
          timeout_set = 1'b1;
          state_d     = REF;
        end
      end
      SETTLE: begin
        // Any lock dropout restarts qualification, including the timeout.
        if (!phy_clk_req)              state_d = REF;
        else if (!lock_s)              state_d = PLL_WAIT;
        else if (cnt_q == SETTLE_LAST) state_d = TO_PHY;
      end
      TO_PHY: begin
        // Request drops are deliberately ignored until the switch completes.
        if (cnt_q == SWITCH_LAST) state_d = PHY;
      end
      PHY: begin
        cnt_d = '0;
        if (!phy_clk_req) state_d = TO_REF;
`ifdef SLINK_CLK_SEQ_LOCK_MONITOR_EN
        else if (!lock_s) begin
          state_d  = TO_REF;
          lost_set = 1'b1;
          block_d  = 1'b1;
        end
`endif
      end
      TO_REF: begin
        if (cnt_q == SWITCH_LAST) state_d = REF;
      end
      default: state_d = REF;
    endcase

    if (state_d != state_q) cnt_d = '0;

    // Outputs are decoded from the next state so they change with the state.
    phy_pll_en_d  = (state_d != REF);
    use_phy_clk_d = (state_d == TO_PHY) || (state_d == PHY);
    link_hold_d   = (state_d == TO_PHY) || (state_d == TO_REF);
    busy_d        = (state_d != REF) && (state_d != PHY);
    on_phy_clk_d  = (state_d == PHY);

    // Sticky errors: a set event wins over a simultaneous clear.
    lock_timeout_err_d = timeout_set | (lock_timeout_err_q & ~err_clr);
`ifdef SLINK_CLK_SEQ_LOCK_MONITOR_EN
    lock_lost_err_d = lost_set | (lock_lost_err_q & ~err_clr);
`endif
  end

  // FSM state, counter and registered outputs; reset forces REF outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q            <= REF;
      cnt_q              <= '0;
      phy_pll_en_q       <= 1'b0;
      use_phy_clk_q      <= 1'b0;
      link_hold_q        <= 1'b0;
      busy_q             <= 1'b0;
      on_phy_clk_q       <= 1'b0;
      lock_timeout_err_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      phy_pll_en_q       <= phy_pll_en_d;
      use_phy_clk_q      <= use_phy_clk_d;
      link_hold_q        <= link_hold_d;
      busy_q             <= busy_d;
      on_phy_clk_q       <= on_phy_clk_d;
      lock_timeout_err_q <= lock_timeout_err_d;
    end
  end

`ifdef SLINK_CLK_SEQ_LOCK_MONITOR_EN
  // Lock-loss flag and the re-arm block that follows a lock loss.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_lost_err_q <= 1'b0;
      block_q         <= 1'b0;
    end else begin
      lock_lost_err_q <= lock_lost_err_d;
      block_q         <= block_d;
    end
  end
  assign lock_lost_err = lock_lost_err_q;
`else
  assign lock_lost_err = 1'b0;
`endif

  assign phy_pll_en       = phy_pll_en_q;
  assign use_phy_clk      = use_phy_clk_q;
  assign link_hold        = link_hold_q;
  assign busy             = busy_q;
  assign on_phy_clk       = on_phy_clk_q;
  assign lock_timeout_err = lock_timeout_err_q;

endmodule

// File: tb/tb_slink_link_clk_seq.sv
// Directed bench for slink_link_clk_seq with small phase lengths.
// Output vector order: {pll_en, use_phy_clk, link_hold, busy, on_phy_clk,
// lock_timeout_err, lock_lost_err}.
module tb_slink_link_clk_seq;

  localparam int LT = 16;
  localparam int SS = 4;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req = 1'b0;
  logic lock = 1'b0;
  logic err_clr = 1'b0;
  logic pll_en, use_clk, hold, busy, on_phy, to_err, lost;
  logic [6:0] outs;

  int checks = 0;
  int errors = 0;

  assign outs = {pll_en, use_clk, hold, busy, on_phy, to_err, lost};

  slink_link_clk_seq #(
    .LOCK_TIMEOUT  (LT),
    .SETTLE_CYCLES (SS),
    .SWITCH_CYCLES (SW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .phy_clk_req      (req),
    .phy_pll_lock     (lock),
    .err_clr          (err_clr),
    .phy_pll_en       (pll_en),
    .use_phy_clk      (use_clk),
    .link_hold        (hold),
    .busy             (busy),
    .on_phy_clk       (on_phy),
    .lock_timeout_err (to_err),
    .lock_lost_err    (lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges; inputs change and outputs are sampled 1ns after.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Measure how many cycles link_hold stays high, starting with it high now.
  task automatic measure_hold(output int n);
    n = 1;
    tick();
    while (hold && n < 50) begin
      n++;
      tick();
    end
  endtask

  // Pulse err_clr for one cycle.
  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  int  n;
  logic seen_use;

  initial begin
    // Reset state
    tick(2);
    check("reset_outs", 32'(outs), 32'h0);
    reset = 1'b1;
    tick(2);
    check("idle_outs", 32'(outs), 32'h0);

    // Nominal switch to PHY clock
    req = 1'b1;
    tick();
    check("pll_wait_outs", 32'(outs), 32'b1001000);
    tick(4);
    lock = 1'b1;
    n = 0;
    while (!use_clk && n < 50) begin
      tick();
      n++;
    end
    check("lock_to_use", n, 2 + SS + 1);
    check("to_phy_outs", 32'(outs), 32'b1111000);
    measure_hold(n);
    check("hold_width_up", n, SW);
    check("phy_outs", 32'(outs), 32'b1100100);

    // Switch back to refclk
    req = 1'b0;
    tick();
    check("to_ref_outs", 32'(outs), 32'b1011000);
    measure_hold(n);
    check("hold_width_down", n, SW);
    check("ref_after_back", 32'(outs), 32'h0);
    lock = 1'b0;
    tick(3);

    // Lock timeout, lock never arrives
    req = 1'b1;
    n = 0;
    seen_use = 1'b0;
    while (!to_err && n < 100) begin
      tick();
      n++;
      if (use_clk) seen_use = 1'b1;
    end
    check("timeout_cycle", n, LT + 1);
    check("timeout_outs", 32'(outs), 32'b0000010);
    check("timeout_no_use", 32'(seen_use), 32'h0);
    req = 1'b0;
    tick();
    check("timeout_sticky", 32'(to_err), 32'h1);
    pulse_clr();
    check("timeout_cleared", 32'(to_err), 32'h0);

    // Timeout coinciding with err_clr: set wins; request held re-arms
    req = 1'b1;
    tick(LT);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("set_wins", 32'(to_err), 32'h1);
    tick();
    check("rearm_pll_en", 32'(pll_en), 32'h1);
    req = 1'b0;
    tick();
    check("rearm_abort_outs", 32'(outs), 32'b0000010);
    pulse_clr();
    check("timeout_cleared2", 32'(to_err), 32'h0);

    // Settle glitch: lock high 2, low 1, then high
    req = 1'b1;
    tick(2);
    lock = 1'b1;
    tick(2);
    lock = 1'b0;
    tick();
    lock = 1'b1;
    n = 3;
    while (!use_clk && n < 60) begin
      tick();
      n++;
    end
    check("glitch_lock_to_use", n, 3 + 2 + SS + 1);
    measure_hold(n);
    check("glitch_hold_width", n, SW);
    check("glitch_phy_outs", 32'(outs), 32'b1100100);

    // Lock loss while on PHY clock
    lock = 1'b0;
    tick(3);
`ifdef SLINK_CLK_SEQ_LOCK_MONITOR_EN
    check("lock_lost_outs", 32'(outs), 32'b1011001);
    measure_hold(n);
    check("lost_hold_width", n, SW);
    lock = 1'b1;
    tick(6);
    check("no_reentry_outs", 32'(outs), 32'b0000001);
    pulse_clr();
    check("lost_cleared", 32'(lost), 32'h0);
    req = 1'b0;
    tick();
`else
    check("lock_ignored_outs", 32'(outs), 32'b1100100);
    req = 1'b0;
    tick();
    measure_hold(n);
    check("ignored_hold_width", n, SW);
    check("ignored_ref_outs", 32'(outs), 32'h0);
    lock = 1'b1;
`endif

    // Asynchronous reset during the third TO_PHY cycle
    tick(3);
    req = 1'b1;
    n = 0;
    while (!use_clk && n < 60) begin
      tick();
      n++;
    end
    check("rst_reach_to_phy", 32'(use_clk), 32'h1);
    tick(2);
    check("rst_hold_before", 32'(hold), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_outs", 32'(outs), 32'h0);
    req = 1'b0;
    #10;
    reset = 1'b1;
    tick(3);
    check("ref_after_reset", 32'(outs), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
